// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide units.
// Holds the FSM state encoding, default width and counter sizing.
package mdu_pkg;

    localparam int MDU_PARALLELISM = 32;

    localparam int MDU_CNT_W = $clog2(MDU_PARALLELISM) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ITER    = 3'd2,
        S_SIGNFIX = 3'd3,
        S_DONE    = 3'd4
    } mdu_state_e;

    // Counter must hold the value N itself, hence one extra bit.
    function automatic int mdu_cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mul_seq_dp.sv
// Datapath of the sequential multiplier: operands, magnitudes,
// shift-add accumulator, iteration counter and final sign fix.
module mul_seq_dp
    import mdu_pkg::*;
#(
    parameter int N = MDU_PARALLELISM
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         accept_i,
    input  logic         load_i,
    input  logic         iter_i,
    input  logic         fix_i,
    input  logic         usigned_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         cnt_last_o,
    output logic [N-1:0] prod_hi_o,
    output logic [N-1:0] prod_lo_o
);

    localparam int CW = mdu_cnt_w(N);
    localparam int W2 = 2 * N;

    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          us_q, us_d;
    logic [W2-1:0] mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic          neg_q, neg_d;
    logic [W2-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W2-1:0] prod_q, prod_d;

    // Most negative value maps onto 2^(N-1) as an unsigned magnitude.
    function automatic logic [N-1:0] mag_f(
        input logic [N-1:0] v,
        input logic         us
    );
        return (!us && v[N-1]) ? -v : v;
    endfunction

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        us_d     = us_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;

        if (accept_i) begin
            a_d  = a_i;
            b_d  = b_i;
            us_d = usigned_i;
        end

        if (load_i) begin
            mcand_d  = {{N{1'b0}}, mag_f(a_q, us_q)};
            mplier_d = mag_f(b_q, us_q);
            neg_d    = ~us_q & (a_q[N-1] ^ b_q[N-1]);
            acc_d    = '0;
            cnt_d    = CW'(N);
        end

        if (iter_i) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end

        if (fix_i) begin
            prod_d = neg_q ? -acc_q : acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            us_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            us_q     <= us_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end

    assign cnt_last_o = (cnt_q == CW'(1));
    assign prod_hi_o  = prod_q[W2-1:N];
    assign prod_lo_o  = prod_q[N-1:0];

endmodule

// File: rtl/mul_seq_unit.sv
// Radix-2 sequential multiplier: control FSM around mul_seq_dp.
// Signed operands are handled as magnitudes with a final negate.
module mul_seq_unit
    import mdu_pkg::*;
#(
    parameter int PARALLELISM = MDU_PARALLELISM
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid,
    input  logic                   usigned,
    input  logic [PARALLELISM-1:0] multiplicand,
    input  logic [PARALLELISM-1:0] multiplier,
    output logic [PARALLELISM-1:0] product_hi,
    output logic [PARALLELISM-1:0] product_lo,
    output logic                   res_ready,
    output logic                   busy
);

    mdu_state_e state_q, state_d;

    logic accept;
    logic load;
    logic iter;
    logic fix;
    logic cnt_last;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        load    = 1'b0;
        iter    = 1'b0;
        fix     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (valid) begin
                    accept  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                load    = 1'b1;
                state_d = S_ITER;
            end
            S_ITER: begin
                iter = 1'b1;
                if (cnt_last) begin
                    state_d = S_SIGNFIX;
                end
            end
            S_SIGNFIX: begin
                fix     = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign res_ready = (state_q == S_DONE);

    mul_seq_dp #(
        .N (PARALLELISM)
    ) u_dp (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept_i   (accept),
        .load_i     (load),
        .iter_i     (iter),
        .fix_i      (fix),
        .usigned_i  (usigned),
        .a_i        (multiplicand),
        .b_i        (multiplier),
        .cnt_last_o (cnt_last),
        .prod_hi_o  (product_hi),
        .prod_lo_o  (product_lo)
    );

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed and small randomized checks of mul_seq_unit at N=32.
module tb_mul_seq_unit;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic          usigned = 1'b0;
    logic [N-1:0]  multiplicand = '0;
    logic [N-1:0]  multiplier = '0;
    logic [N-1:0]  product_hi;
    logic [N-1:0]  product_lo;
    logic          res_ready;
    logic          busy;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [63:0]   last_prod = '0;
    logic          rr_prev = 1'b0;

    always #5 clk = ~clk;

    mul_seq_unit #(
        .PARALLELISM (N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid        (valid),
        .usigned      (usigned),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product_hi   (product_hi),
        .product_lo   (product_lo),
        .res_ready    (res_ready),
        .busy         (busy)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic us,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (us) return {32'b0, a} * {32'b0, b};
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        return 64'(sa * sb);
    endfunction

    // res_ready is a single-cycle pulse and only seen while busy.
    always @(negedge clk) begin
        if (rst_n && res_ready) begin
            chk("rr_width", {63'b0, rr_prev}, 64'd0);
            chk("rr_busy", {63'b0, busy}, 64'd1);
        end
        rr_prev = rst_n & res_ready;
    end

    task automatic start(input logic us,
                         input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        valid        = 1'b1;
        usigned      = us;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        #1;
        valid        = 1'b0;
        usigned      = ~us;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    task automatic wait_done(input string tag,
                             input logic [63:0] exp,
                             input int exp_k);
        int k = 0;
        bit seen = 1'b0;
        while (!seen && k < 80) begin
            @(negedge clk);
            k++;
            if (res_ready) begin
                seen = 1'b1;
            end else if (k == 20) begin
                chk({tag, "_hold"}, {product_hi, product_lo}, last_prod);
                chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
            end
        end
        chk({tag, "_seen"}, {63'b0, seen}, 64'd1);
        chk({tag, "_lat"}, 64'(k), 64'(exp_k));
        chk({tag, "_prod"}, {product_hi, product_lo}, exp);
        last_prod = exp;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rus;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_rr", {63'b0, res_ready}, 64'd0);
        chk("rst_prod", {product_hi, product_lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", {63'b0, busy}, 64'd0);

        start(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("u_max", 64'hFFFFFFFE_00000001, 35);
        start(1'b0, 32'hFFFFFFFF, 32'h00000001);
        wait_done("s_m1x1", 64'hFFFFFFFF_FFFFFFFF, 35);
        start(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("s_m1xm1", 64'h00000000_00000001, 35);
        start(1'b0, 32'h80000000, 32'h80000000);
        wait_done("s_minsq", 64'h40000000_00000000, 35);
        start(1'b0, 32'h80000000, 32'h00000001);
        wait_done("s_minx1", 64'hFFFFFFFF_80000000, 35);
        start(1'b1, 32'h80000000, 32'h80000000);
        wait_done("u_msbsq", 64'h40000000_00000000, 35);
        start(1'b1, 32'hFFFFFFFF, 32'h00000002);
        wait_done("u_maxx2", 64'h00000001_FFFFFFFE, 35);
        start(1'b0, 32'hFFFFFFFD, 32'h00000007);
        wait_done("s_m3x7", 64'hFFFFFFFF_FFFFFFEB, 35);
        start(1'b0, 32'h00000007, 32'hFFFFFFFD);
        wait_done("s_7xm3", 64'hFFFFFFFF_FFFFFFEB, 35);
        start(1'b0, 32'h00001000, 32'h00000010);
        wait_done("s_pos", 64'h00000000_00010000, 35);

        start(1'b1, 32'd7, 32'd6);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 10) begin
                chk("mid_busy", {63'b0, busy}, 64'd1);
                valid        = 1'b1;
                usigned      = 1'b0;
                multiplicand = 32'd3;
                multiplier   = 32'd3;
            end
        end
        @(negedge clk);
        valid = 1'b0;
        wait_done("ignore", 64'd42, 24);
        start(1'b1, 32'h00000000, 32'h12345678);
        wait_done("b2b_zero", 64'd0, 35);

        start(1'b1, 32'd5, 32'd5);
        repeat (19) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b1;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        @(posedge clk);
        #1;
        chk("mrst_busy", {63'b0, busy}, 64'd0);
        chk("mrst_rr", {63'b0, res_ready}, 64'd0);
        chk("mrst_prod", {product_hi, product_lo}, 64'd0);
        @(posedge clk);
        #1;
        chk("rst_valid", {63'b0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst", {62'b0, busy, res_ready}, 64'd0);
        last_prod = '0;
        start(1'b1, 32'd2, 32'd3);
        wait_done("after_rst", 64'd6, 35);

        for (int i = 0; i < 150; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rus = 1'($urandom_range(0, 1));
            if (i % 10 == 0) ra = 32'h80000000;
            start(rus, ra, rb);
            wait_done("rand", ref_mul(rus, ra, rb), 35);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_seq_unit.md
MUL_SEQ_UNIT -- requirements
Module: mul_seq_unit

Interface
REQ-001 Parameter PARALLELISM, default 32: operand width N; legal values are even and at least 4.
REQ-002 Reset rst_n, synchronous, active-low; clock clk.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 valid  input  1  start request; sampled only in IDLE.
REQ-006 usigned  input  1  1 = unsigned operands, 0 = two's-complement operands; sampled with valid.
REQ-007 multiplicand  input  N  operand A; sampled with valid.
REQ-008 multiplier  input  N  operand B; sampled with valid.
REQ-009 product_hi  output  N  upper half of the 2N-bit product.
REQ-010 product_lo  output  N  lower half of the 2N-bit product.
REQ-011 res_ready  output  1  one-cycle pulse; product valid.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, LOAD, ITER, SIGNFIX, DONE.
REQ-014 IDLE with valid=1 -> LOAD; operands and usigned latched on that edge.
REQ-015 IDLE with valid=0 -> IDLE.
REQ-016 LOAD (1 cycle):
- latch magnitudes of both operands (negate if signed and MSB=1);
- latch neg_flag = signed & (A[N-1] xor B[N-1]);
- clear the 2N-bit accumulator;
- load the iteration counter with N.
REQ-017 Magnitude of 0x80..0 in signed mode is 2^(N-1) as an unsigned N-bit value; no overflow flag.
REQ-018 ITER: radix-2 shift-add, one multiplier bit per cycle, LSB first; the counter decrements; exactly N cycles; counter reaching 0 -> SIGNFIX.
REQ-019 SIGNFIX (1 cycle): product_hi/product_lo <= neg_flag ? two's-complement negation of the 2N-bit accumulator : accumulator.
REQ-020 DONE (1 cycle): res_ready=1; -> IDLE unconditionally.
REQ-021 Latency: valid accepted at edge t -> res_ready high during cycle t+N+3 (t+35 for N=32); minimum issue interval N+4 cycles.
REQ-022 product_hi/product_lo change only in SIGNFIX; they hold their value until the next SIGNFIX.
REQ-023 valid, usigned and operand changes while busy=1 are ignored; no queuing.
REQ-024 valid=1 in the cycle after DONE (state IDLE) is accepted normally (back-to-back).
REQ-025 Signed results are exact 2N-bit two's complement, including (-2^(N-1))^2 = 2^(2N-2).
REQ-026 Unsigned results are exact 2N-bit unsigned products.
REQ-027 Zero operand: normal latency, product 0, no early termination.

Reset
REQ-028 rst_n=0 at an edge -> state IDLE, counter 0, accumulator 0, product_hi=0, product_lo=0, res_ready=0, busy=0.
REQ-029 Reset mid-operation abandons the operation; no res_ready for it; outputs read 0 at the next cycle.
REQ-030 valid is ignored in any cycle where rst_n=0.

Structure
REQ-031 Shared package mdu_pkg holds:
- the FSM state enum typedef;
- the default PARALLELISM constant;
- a counter-width constant $clog2(N)+1.
mdu_pkg is shared with the divider.
REQ-032 One sub-module, mul_seq_dp, holds operand, accumulator, counter and negate logic; mul_seq_unit holds the FSM and instantiates mul_seq_dp.
REQ-033 The datapath is purely registered; no combinational path from inputs to outputs.

Verification (N=32)
REQ-034 Unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; res_ready exactly 35 cycles after valid accepted, width 1 cycle.
REQ-035 Signed 0xFFFFFFFF*0x00000001 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF; signed 0xFFFFFFFF*0xFFFFFFFF -> hi=0, lo=0x00000001.
REQ-036 Signed 0x80000000*0x80000000 -> hi=0x40000000, lo=0; signed 0x80000000*0x00000001 -> hi=0xFFFFFFFF, lo=0x80000000.
REQ-037 Start 7*6 and pulse valid with 3*3 at cycle 10 -> single result 42, busy stays high throughout; then back-to-back valid in the cycle after DONE with 0*0x12345678 -> 0 after 35 cycles.
REQ-038 Start 5*5, assert rst_n=0 at cycle 20 -> no res_ready, outputs 0; 2*3 issued after release -> 6 with standard latency.
REQ-039 Random 10k signed/unsigned operand pairs checked against a 2N-bit reference model; busy/res_ready protocol checked by assertions.
